axi_tdd_ng_sync_mon: RTL



---
 rtl/axi_tdd_ng_sync_mon_pkg.sv | 23 ++
 rtl/axi_tdd_ng_sync_mon_edge.sv | 38 +++
 rtl/axi_tdd_ng_sync_mon.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_tdd_ng_sync_mon_pkg.sv
// Shared types for the TDD sync monitor: FSM state encoding and helpers.
package axi_tdd_ng_sync_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEARCH   = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_HOLDOVER = 3'd4
    } sync_state_t;

    localparam logic [2:0] SYNC_ST_IDLE     = 3'd0;
    localparam logic [2:0] SYNC_ST_SEARCH   = 3'd1;
    localparam logic [2:0] SYNC_ST_ACQUIRE  = 3'd2;
    localparam logic [2:0] SYNC_ST_LOCKED   = 3'd3;
    localparam logic [2:0] SYNC_ST_HOLDOVER = 3'd4;

    // Lock is reported in both the tracking and the flywheel states.
    function automatic logic state_is_locked(input sync_state_t st);
        return (st == ST_LOCKED) || (st == ST_HOLDOVER);
    endfunction

endpackage

// File: rtl/axi_tdd_ng_sync_mon_edge.sv
// Optional 3-flop synchronizer plus rising-edge detector for the sync input.
// Everything clears while reset or disabled so a re-enable starts clean.
module axi_tdd_ng_sync_mon_edge #(
    parameter int SYNC_EXTERNAL_CDC = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic sync_in,
    output logic sync_edge
);

    generate
        if (SYNC_EXTERNAL_CDC != 0) begin : g_cdc
            // sync_m[0..2] = m1..m3; the edge is taken between m2 and m3
            logic [2:0] sync_m;

            // Shift the asynchronous input through the synchronizer chain
            always_ff @(posedge clk) begin
                if (!resetn || !enable) sync_m <= 3'b000;
                else                    sync_m <= {sync_m[1:0], sync_in};
            end

            assign sync_edge = sync_m[1] & ~sync_m[2];
        end else begin : g_direct
            logic sync_in_d;

            // Delay the already-synchronous input by one cycle for edge detect
            always_ff @(posedge clk) begin
                if (!resetn || !enable) sync_in_d <= 1'b0;
                else                    sync_in_d <= sync_in;
            end

            assign sync_edge = enable & sync_in & ~sync_in_d;
        end
    endgenerate

endmodule

// File: rtl/axi_tdd_ng_sync_mon.sv
// TDD sync monitor: qualifies incoming sync edges against the programmed
// period/tolerance window, locks after consecutive good periods and
// flywheels through a bounded number of missing edges.
module axi_tdd_ng_sync_mon
    import axi_tdd_ng_sync_mon_pkg::*;
#(
    parameter int SYNC_EXTERNAL_CDC = 0,
    parameter int SYNC_COUNT_WIDTH  = 64,
    parameter int TOL_WIDTH         = 16,
    parameter int LOCK_COUNT        = 3,
    parameter int HOLDOVER_MAX      = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sync_in,
    input  logic                        tdd_enable,
    input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_period,
    input  logic [TOL_WIDTH-1:0]        tdd_sync_tolerance,
    output logic                        sync_out,
    output logic                        sync_locked,
    output logic                        sync_early,
    output logic                        sync_missed,
    output logic                        sync_lost,
    output logic [SYNC_COUNT_WIDTH-1:0] sync_period_meas,
    output logic [2:0]                  sync_state
);

    localparam int W  = SYNC_COUNT_WIDTH;
    localparam int WX = SYNC_COUNT_WIDTH + 1;

    sync_state_t  state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [7:0]   acq_cnt, acq_nxt;
    logic [7:0]   miss_cnt, miss_nxt;

    logic         out_nxt, early_nxt, missed_nxt, lost_nxt;
    logic [W-1:0] meas_nxt;

    logic         sync_edge;
    logic [WX-1:0] p_ext, p_m1, t_ext, c_ext, win_lo, win_hi;
    logic         period_ok, edge_in, edge_early, miss;
    logic         acq_done, hold_done;
    logic [W-1:0] tol_cnt;

    axi_tdd_ng_sync_mon_edge #(
        .SYNC_EXTERNAL_CDC(SYNC_EXTERNAL_CDC)
    ) u_edge (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (tdd_enable),
        .sync_in  (sync_in),
        .sync_edge(sync_edge)
    );

    // Window arithmetic is one bit wider so hi = P-1+T never wraps.
    assign p_ext     = {1'b0, tdd_sync_period};
    assign p_m1      = p_ext - WX'(1);
    assign t_ext     = WX'(tdd_sync_tolerance);
    assign c_ext     = {1'b0, cnt};
    assign win_lo    = (p_m1 > t_ext) ? (p_m1 - t_ext) : '0;
    assign win_hi    = p_m1 + t_ext;
    assign period_ok = (p_ext >= WX'(2));
    assign tol_cnt   = W'(tdd_sync_tolerance);

    assign edge_early = sync_edge & (c_ext < win_lo);
    assign edge_in    = sync_edge & (c_ext >= win_lo) & (c_ext <= win_hi);
    // An edge landing exactly on hi wins over the miss.
    assign miss       = ~sync_edge & (c_ext == win_hi);

    assign acq_done  = ({1'b0, acq_cnt} + 9'd1)  >= 9'(LOCK_COUNT);
    assign hold_done = ({1'b0, miss_cnt} + 9'd1) >= 9'(HOLDOVER_MAX);

    // State, counters and registered outputs; disable behaves like reset
    always_ff @(posedge clk) begin
        if (!resetn || !tdd_enable) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            acq_cnt          <= '0;
            miss_cnt         <= '0;
            sync_out         <= 1'b0;
            sync_early       <= 1'b0;
            sync_missed      <= 1'b0;
            sync_lost        <= 1'b0;
            sync_period_meas <= '0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            acq_cnt          <= acq_nxt;
            miss_cnt         <= miss_nxt;
            sync_out         <= out_nxt;
            sync_early       <= early_nxt;
            sync_missed      <= missed_nxt;
            sync_lost        <= lost_nxt;
            sync_period_meas <= meas_nxt;
        end
    end

    // Next-state and counter update from the window classification
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + W'(1);
        acq_nxt   = acq_cnt;
        miss_nxt  = miss_cnt;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_SEARCH;
                cnt_nxt   = '0;
                acq_nxt   = '0;
                miss_nxt  = '0;
            end
            ST_SEARCH: begin
                cnt_nxt = '0;
                if (sync_edge) begin
                    state_nxt = ST_ACQUIRE;
                    acq_nxt   = '0;
                end
            end
            ST_ACQUIRE: begin
                if (edge_in) begin
                    cnt_nxt = '0;
                    if (acq_done) begin
                        state_nxt = ST_LOCKED;
                        acq_nxt   = '0;
                        miss_nxt  = '0;
                    end else begin
                        acq_nxt = acq_cnt + 8'd1;
                    end
                end else if (edge_early) begin
                    cnt_nxt = '0;
                    acq_nxt = '0;
                end else if (miss) begin
                    state_nxt = ST_SEARCH;
                    cnt_nxt   = '0;
                    acq_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (edge_in) begin
                    cnt_nxt = '0;
                end else if (miss) begin
                    // Reload with T so the flywheel keeps the nominal phase
                    cnt_nxt   = tol_cnt;
                    miss_nxt  = 8'd1;
                    state_nxt = ST_HOLDOVER;
                end
            end
            ST_HOLDOVER: begin
                if (edge_in) begin
                    cnt_nxt   = '0;
                    miss_nxt  = '0;
                    state_nxt = ST_LOCKED;
                end else if (miss) begin
                    if (hold_done) begin
                        state_nxt = ST_SEARCH;
                        cnt_nxt   = '0;
                        miss_nxt  = '0;
                    end else begin
                        cnt_nxt  = tol_cnt;
                        miss_nxt = miss_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A degenerate period parks the monitor in SEARCH and ignores edges.
        if (!period_ok && state != ST_IDLE) begin
            state_nxt = ST_SEARCH;
            cnt_nxt   = '0;
            acq_nxt   = '0;
            miss_nxt  = '0;
        end
    end

    // Next values of the registered pulses and the period measurement
    always_comb begin
        out_nxt    = 1'b0;
        early_nxt  = 1'b0;
        missed_nxt = 1'b0;
        lost_nxt   = 1'b0;
        meas_nxt   = sync_period_meas;
        if (period_ok) begin
            case (state)
                ST_ACQUIRE: begin
                    if (edge_in && acq_done) begin
                        out_nxt  = 1'b1;
                        meas_nxt = cnt + W'(1);
                    end
                    early_nxt = edge_early;
                end
                ST_LOCKED, ST_HOLDOVER: begin
                    if (edge_in) begin
                        out_nxt  = 1'b1;
                        meas_nxt = cnt + W'(1);
                    end else if (miss) begin
                        missed_nxt = 1'b1;
                        if (state == ST_HOLDOVER && hold_done) lost_nxt = 1'b1;
                        else                                   out_nxt  = 1'b1;
                    end
                    early_nxt = edge_early;
                end
                default: ;
            endcase
        end
    end

    assign sync_state  = state;
    assign sync_locked = state_is_locked(state);

endmodule
